updown_ctrl: RTL and testbench

Input-conditioning and pacing stage directly upstream of the 4-bit up/down counter. Cleans the raw direction push-button, toggles a registered count direction on each debounced press, and issues a single-cycle step enable at a fixed rate. The counter's next-state logic takes `dir` in place of its raw button input and advances its state register only on `step`, all on `clk`.

---
 rtl/updown_pkg.sv | 9 +
 rtl/btn_sync_2ff.sv | 15 +
 rtl/updown_ctrl.sv | 86 ++++++++
 tb/tb_updown_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/updown_pkg.sv
// updown_pkg: shared types and direction constants for the up/down counter front end.
package updown_pkg;

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} ctrl_state_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/btn_sync_2ff.sv
// btn_sync_2ff: two-flop synchronizer for an asynchronous input.
module btn_sync_2ff (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk or posedge clr)
        if (clr) {q, s1} <= 2'b00;
        else     {q, s1} <= {s1, d};

endmodule

// File: rtl/updown_ctrl.sv
// updown_ctrl: debounces the direction button, toggles dir per press and paces the counter with step.
module updown_ctrl
    import updown_pkg::*;
#(
    parameter int DB_CYCLES = 1_000_000,
    parameter int TICK_DIV  = 25
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic dir,
    output logic db_lvl,
    output logic press,
    output logic step
);

    localparam int CW = $clog2(DB_CYCLES);
    // The sample that leaves IDLE/HELD is the first stable one, so DB_CYCLES samples end at DB_CYCLES-2.
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 2);

    ctrl_state_t         state;
    logic [CW-1:0]       cnt;
    logic [TICK_DIV-1:0] tick;
    logic                s2;

    btn_sync_2ff u_sync (
        .clk (clk),
        .clr (clr),
        .d   (btn),
        .q   (s2)
    );

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            state  <= IDLE;
            cnt    <= '0;
            dir    <= DIR_UP;
            db_lvl <= 1'b0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            case (state)
                IDLE:
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                PRESS_WAIT:
                    if (!s2) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state  <= HELD;
                        cnt    <= '0;
                        db_lvl <= 1'b1;
                        press  <= 1'b1;
                        dir    <= ~dir;
                    end else cnt <= cnt + CW'(1);
                HELD:
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                RELEASE_WAIT:
                    if (s2) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        db_lvl <= 1'b0;
                    end else cnt <= cnt + CW'(1);
                default: state <= IDLE;
            endcase
        end

    always_ff @(posedge clk or posedge clr)
        if (clr) begin
            tick <= '0;
            step <= 1'b0;
        end else begin
            tick <= tick + TICK_DIV'(1);
            step <= &tick;
        end

endmodule

// File: tb/tb_updown_ctrl.sv
// tb_updown_ctrl: directed checks of debounce, press/dir behaviour and step cadence.
module tb_updown_ctrl;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic btn = 1'b0;
    logic dir, db_lvl, press, step;
    int checks = 0;
    int passed = 0;

    updown_ctrl #(.DB_CYCLES(4), .TICK_DIV(3)) dut (
        .clk    (clk),
        .clr    (clr),
        .btn    (btn),
        .dir    (dir),
        .db_lvl (db_lvl),
        .press  (press),
        .step   (step)
    );

    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Leaves the bench on a falling edge with clr low; the next rising edge is edge 1.
    task automatic apply_reset();
        @(negedge clk);
        clr = 1'b1;
        btn = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        btn = 1'b1;
        tick_n(8);
        checks++; if (db_lvl !== 1'b1 || dir !== 1'b0 || step !== 1'b1) $display("FAIL reset_pre: db_lvl=%b dir=%b step=%b expected 1 0 1", db_lvl, dir, step); else passed++;
        #2;
        clr = 1'b1;
        #1;
        checks++; if (dir !== 1'b1) $display("FAIL reset_dir: got %b expected 1", dir); else passed++;
        checks++; if (db_lvl !== 1'b0) $display("FAIL reset_db_lvl: got %b expected 0", db_lvl); else passed++;
        checks++; if (press !== 1'b0) $display("FAIL reset_press: got %b expected 0", press); else passed++;
        checks++; if (step !== 1'b0) $display("FAIL reset_step: got %b expected 0", step); else passed++;
        @(negedge clk);
        clr = 1'b0;
        btn = 1'b0;
    endtask

    task automatic test_clean_press();
        apply_reset();
        tick_n(9);
        btn = 1'b1;
        for (int e = 10; e <= 18; e++) begin
            tick_n(1);
            checks++; if (press !== (e == 15)) $display("FAIL clean_press edge %0d: press=%b expected %b", e, press, e == 15); else passed++;
            checks++; if (db_lvl !== (e >= 15)) $display("FAIL clean_db_lvl edge %0d: db_lvl=%b expected %b", e, db_lvl, e >= 15); else passed++;
            checks++; if (dir !== (e < 15)) $display("FAIL clean_dir edge %0d: dir=%b expected %b", e, dir, e < 15); else passed++;
        end
        btn = 1'b0;
    endtask

    task automatic test_bounce();
        logic seen_press, seen_lvl;
        seen_press = 1'b0;
        seen_lvl = 1'b0;
        apply_reset();
        for (int i = 0; i < 20; i++) begin
            btn = (i < 3) || (i >= 4 && i < 7);
            tick_n(1);
            seen_press |= press;
            seen_lvl |= db_lvl;
        end
        checks++; if (seen_press !== 1'b0) $display("FAIL bounce_press: seen=%b expected 0", seen_press); else passed++;
        checks++; if (seen_lvl !== 1'b0) $display("FAIL bounce_db_lvl: seen=%b expected 0", seen_lvl); else passed++;
        checks++; if (dir !== 1'b1) $display("FAIL bounce_dir: got %b expected 1", dir); else passed++;
    endtask

    task automatic test_hold_release();
        int npress;
        npress = 0;
        apply_reset();
        btn = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick_n(1);
            npress += int'(press);
        end
        checks++; if (npress != 1) $display("FAIL hold_presses: got %0d expected 1", npress); else passed++;
        checks++; if (db_lvl !== 1'b1 || dir !== 1'b0) $display("FAIL hold_state: db_lvl=%b dir=%b expected 1 0", db_lvl, dir); else passed++;
        npress = 0;
        for (int i = 0; i < 4; i++) begin
            btn = logic'(i % 2);
            tick_n(1);
            npress += int'(press);
        end
        btn = 1'b0;
        for (int e = 0; e <= 6; e++) begin
            tick_n(1);
            npress += int'(press);
            checks++; if (db_lvl !== (e < 5)) $display("FAIL release_db_lvl k+%0d: db_lvl=%b expected %b", e, db_lvl, e < 5); else passed++;
        end
        checks++; if (npress != 0) $display("FAIL release_presses: got %0d expected 0", npress); else passed++;
        checks++; if (dir !== 1'b0) $display("FAIL release_dir: got %b expected 0", dir); else passed++;
    endtask

    task automatic test_step_cadence();
        apply_reset();
        for (int e = 1; e <= 40; e++) begin
            tick_n(1);
            checks++; if (step !== (e % 8 == 0)) $display("FAIL step edge %0d: step=%b expected %b", e, step, e % 8 == 0); else passed++;
        end
    endtask

    task automatic test_coincidence();
        apply_reset();
        for (int e = 1; e <= 17; e++) begin
            if (e == 11) btn = 1'b1;
            tick_n(1);
            if (e == 15) begin
                checks++; if (press !== 1'b0 || dir !== 1'b1) $display("FAIL coinc_before: press=%b dir=%b expected 0 1", press, dir); else passed++;
            end
            if (e == 16) begin
                checks++; if (press !== 1'b1) $display("FAIL coinc_press: got %b expected 1", press); else passed++;
                checks++; if (step !== 1'b1) $display("FAIL coinc_step: got %b expected 1", step); else passed++;
                checks++; if (dir !== 1'b0) $display("FAIL coinc_dir: got %b expected 0", dir); else passed++;
            end
        end
        btn = 1'b0;
    endtask

    task automatic test_clr_press_wait();
        apply_reset();
        btn = 1'b1;
        tick_n(4);
        checks++; if (press !== 1'b0 || db_lvl !== 1'b0) $display("FAIL pw_pre: press=%b db_lvl=%b expected 0 0", press, db_lvl); else passed++;
        #2;
        clr = 1'b1;
        #1;
        checks++; if (press !== 1'b0 || db_lvl !== 1'b0 || dir !== 1'b1) $display("FAIL pw_clr: press=%b db_lvl=%b dir=%b expected 0 0 1", press, db_lvl, dir); else passed++;
        @(negedge clk);
        clr = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick_n(1);
            checks++; if (press !== (e == 6)) $display("FAIL pw_restart_press edge %0d: press=%b expected %b", e, press, e == 6); else passed++;
            checks++; if (dir !== (e < 6)) $display("FAIL pw_restart_dir edge %0d: dir=%b expected %b", e, dir, e < 6); else passed++;
        end
        btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_hold_release();
        test_step_cadence();
        test_coincidence();
        test_clr_press_wait();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
